// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional build macro used by the arbiter files: FIFO_ARB_PRIO0_EN.
`timescale 1ns/1ps

package fifo_arb_pkg;

  // Arbiter FSM: one cycle of arbitration, then ownership of the write port.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of the per-grant beat counter. It has to hold BURST_LEN itself.
  function automatic int beat_cnt_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker. It searches req upward from ptr and wraps.
// When FIFO_ARB_PRIO0_EN is defined, requester 0 wins whenever it requests.
`timescale 1ns/1ps

module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0]   pick_idx
);

  // The first requester at or after ptr wins. If none is found, the outputs are zero.
  always_comb begin
    int         cand;
    logic       found;
    logic [IDX_W-1:0] cand_idx;
    pick_oh  = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found    = 1'b1;
        pick_idx = cand_idx;
      end
    end
`ifdef FIFO_ARB_PRIO0_EN
    if (req[0]) pick_idx = '0;
`else
`endif
    if (found) pick_oh[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for the single write port of the async FIFO.
// The grant lasts for up to BURST_LEN words. While flag_full is high the
// owner stalls and keeps the grant. Optional macro FIFO_ARB_PRIO0_EN gives
// requester 0 fixed priority in IDLE.
`timescale 1ns/1ps

module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATAIN_WIDTH = 16,
  parameter int BURST_LEN    = 4
) (
  input  logic                            w_clk,
  input  logic                            w_rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATAIN_WIDTH-1:0] req_data,
  input  logic                            flag_full,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            w_en,
  output logic [DATAIN_WIDTH-1:0]         data_write
);

  localparam int                IDX_W     = $clog2(NUM_REQ);
  localparam int                BEAT_W    = beat_cnt_w(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

  arb_state_e         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [BEAT_W-1:0]  beat;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic [BEAT_W-1:0]  beat_next;
  logic               grant_exit;
  logic [IDX_W-1:0]   ptr_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .ptr      (ptr),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx)
  );

  // Write strobe, ack and data follow the owner's request in the same cycle, gated by full.
  always_comb begin
    w_en       = (state == GRANT) & req[owner] & ~flag_full;
    ack        = w_en ? gnt : '0;
    data_write = w_en ? req_data[int'(owner)*DATAIN_WIDTH +: DATAIN_WIDTH] : '0;
  end

  // Release on the last beat of the burst or when the owner withdraws; rotate the pointer past the owner.
  always_comb begin
    beat_next  = beat + BEAT_W'(1);
    grant_exit = (w_en && (beat_next == BEAT_LAST)) || !req[owner];
    ptr_next   = (owner == IDX_LAST) ? '0 : owner + IDX_W'(1);
`ifdef FIFO_ARB_PRIO0_EN
    if (owner == '0) ptr_next = ptr;
`else
`endif
  end

  // Arbitration FSM: pick in IDLE, count beats and decide release in GRANT.
  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      owner <= '0;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= pick_oh;
            owner <= pick_idx;
            beat  <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (w_en) beat <= beat_next;
          if (grant_exit) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= ptr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NUM_REQ=4, DATAIN_WIDTH=16, BURST_LEN=4).
// Requester i presents word 16'hA000 | i<<8 | n, where n is the number of words of i acked so far.
`timescale 1ns/1ps

module tb_fifo_write_arbiter;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic        flag_full;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        w_en;
  logic [15:0] data_write;

  int n_chk = 0;
  int n_err = 0;
  int cnt [4];
  int rem [4];

  always #5 w_clk = ~w_clk;

  fifo_write_arbiter #(
    .NUM_REQ      (4),
    .DATAIN_WIDTH (16),
    .BURST_LEN    (4)
  ) dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .req        (req),
    .req_data   (req_data),
    .flag_full  (flag_full),
    .gnt        (gnt),
    .ack        (ack),
    .w_en       (w_en),
    .data_write (data_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input int i);
    return 16'hA000 | 16'(i << 8) | 16'(cnt[i]);
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i]             = (rem[i] != 0);
      req_data[i*16 +: 16] = word_of(i);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gnt"},  32'(gnt),        32'h0);
    chk({tag, ".ack"},  32'(ack),        32'h0);
    chk({tag, ".wen"},  32'(w_en),       32'h0);
    chk({tag, ".data"}, 32'(data_write), 32'h0);
  endtask

  // One write-clock cycle: check at negedge, then let the requesters react to ack.
  task automatic step(input string tag, input logic [3:0] eg, input logic [3:0] ea);
    logic [15:0] ed;
    logic [3:0]  seen;
    @(negedge w_clk);
    ed = 16'h0;
    for (int i = 0; i < 4; i++) if (ea[i]) ed = word_of(i);
    chk({tag, ".gnt"},  32'(gnt),              32'(eg));
    chk({tag, ".ack"},  32'(ack),              32'(ea));
    chk({tag, ".wen"},  32'(w_en),             32'(|ea));
    chk({tag, ".data"}, 32'(data_write),       32'(ed));
    chk({tag, ".wff"},  32'(w_en & flag_full), 32'h0);
    seen = ack;
    @(posedge w_clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (seen[i]) begin
        cnt[i]++;
        rem[i]--;
      end
    end
    drive();
  endtask

  task automatic burst(input string tag, input logic [3:0] oh, input int n);
    for (int b = 0; b < n; b++) step($sformatf("%s.b%0d", tag, b), oh, oh);
  endtask

  task automatic do_reset(input string tag, input int r0, input int r1, input int r2, input int r3);
    w_rst     = 1'b0;
    flag_full = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
    drive();
    @(negedge w_clk);
    chk_zero({tag, ".rst"});
    @(posedge w_clk);
    #1;
    w_rst = 1'b1;
  endtask

  initial begin
    req       = 4'h0;
    req_data  = 64'h0;
    flag_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      rem[i] = 0;
    end

    // Reset with all requesting, then continuous rotation 0,1,2,3,0.
    do_reset("t1", 100, 100, 100, 100);
    step("t1.first", 4'b0000, 4'b0000);
    for (int g = 0; g < 5; g++) begin
      burst($sformatf("t2.g%0d", g), 4'b0001 << (g % 4), 4);
      step($sformatf("t2.idle%0d", g), 4'b0000, 4'b0000);
    end

    // req2 alone, req0 arrives mid-burst: req2 finishes first.
    do_reset("t3", 0, 0, 4, 0);
    step("t3.arb", 4'b0000, 4'b0000);
    step("t3.r2b0", 4'b0100, 4'b0100);
    rem[0] = 4;
    drive();
    burst("t3.r2", 4'b0100, 3);
    step("t3.idle", 4'b0000, 4'b0000);
    burst("t3.r0", 4'b0001, 4);
    step("t3.end", 4'b0000, 4'b0000);

    // FIFO full for 5 cycles after req1's second beat.
    do_reset("t4", 0, 4, 0, 0);
    step("t4.arb", 4'b0000, 4'b0000);
    burst("t4.pre", 4'b0010, 2);
    flag_full = 1'b1;
    for (int s = 0; s < 5; s++) step($sformatf("t4.stall%0d", s), 4'b0010, 4'b0000);
    flag_full = 1'b0;
    burst("t4.post", 4'b0010, 2);
    step("t4.idle", 4'b0000, 4'b0000);
    chk("t4.words1", 32'(cnt[1]), 32'd4);
    chk("t4.rem1",   32'(rem[1]), 32'd0);

    // req1 withdraws after 2 words; req3 is next, then withdraws after 3.
    do_reset("t5", 0, 2, 0, 3);
    step("t5.arb", 4'b0000, 4'b0000);
    burst("t5.r1", 4'b0010, 2);
    step("t5.r1rel", 4'b0010, 4'b0000);
    step("t5.idle", 4'b0000, 4'b0000);
    burst("t5.r3", 4'b1000, 3);
    step("t5.r3rel", 4'b1000, 4'b0000);
    step("t5.end", 4'b0000, 4'b0000);

    // Reset pulse in the middle of req1's burst; arbitration restarts at pointer 0.
    do_reset("t6", 10, 10, 0, 0);
    step("t6.arb", 4'b0000, 4'b0000);
    burst("t6.r0", 4'b0001, 4);
    step("t6.idle", 4'b0000, 4'b0000);
    burst("t6.r1", 4'b0010, 2);
    #2;
    w_rst = 1'b0;
    #1;
    chk_zero("t6.mid");
    @(posedge w_clk);
    #1;
    w_rst = 1'b1;
    step("t6.rearb", 4'b0000, 4'b0000);
    burst("t6.r0b", 4'b0001, 4);
    step("t6.idle2", 4'b0000, 4'b0000);
    burst("t6.r1b", 4'b0010, 4);

    // req0 and req3 both requesting.
    do_reset("t7", 8, 0, 0, 4);
    step("t7.arb", 4'b0000, 4'b0000);
`ifdef FIFO_ARB_PRIO0_EN
    burst("t7.a", 4'b0001, 4);
    step("t7.i1", 4'b0000, 4'b0000);
    burst("t7.b", 4'b0001, 4);
    step("t7.i2", 4'b0000, 4'b0000);
    burst("t7.c", 4'b1000, 4);
    step("t7.i3", 4'b0000, 4'b0000);
`else
    burst("t7.a", 4'b0001, 4);
    step("t7.i1", 4'b0000, 4'b0000);
    burst("t7.b", 4'b1000, 4);
    step("t7.i2", 4'b0000, 4'b0000);
    burst("t7.c", 4'b0001, 4);
    step("t7.i3", 4'b0000, 4'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
